// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: opcodes, FSM states,
// ALU codes, mux selects and the per-state control word.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_B   = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALUWB, S_BRANCH, S_JAL, S_ILLEGAL
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SHL = 3'b001;
    localparam logic [2:0] ALU_SUB = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SHR = 3'b101;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;
    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    // Moore control word held in a register alongside the state
    typedef struct packed {
        logic       mem_req;
        logic       mem_write;
        logic       adr_src;
        logic       ir_write;
        logic       pc_update;
        logic       branch;
        logic       reg_write;
        logic       illegal;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic [1:0] alu_op;
    } ctrl_t;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_B:    return IMM_B;
            OP_JAL:  return IMM_J;
            OP_LUI:  return IMM_U;
            default: return IMM_I;
        endcase
    endfunction

    // Only beq/bne/blt/bge are supported; unsigned compares are rejected
    function automatic logic branch_legal(input logic [2:0] funct3);
        return (funct3 == 3'b000) || (funct3 == 3'b001) ||
               (funct3 == 3'b100) || (funct3 == 3'b101);
    endfunction

    // Signed compares use the raw sign of rs1-rs2; overflow is not corrected
    function automatic logic branch_taken(input logic [2:0] funct3,
                                          input logic zero, input logic sign);
        case (funct3)
            3'b000:  return zero;
            3'b001:  return ~zero;
            3'b100:  return sign;
            3'b101:  return ~sign;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps alu_op plus instruction function bits to an ALU operation code.
// The illegal flag reports ALU-type funct encodings the core does not implement.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] i_alu_op,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    input  logic       i_op5,
    output logic [2:0] o_alu_control,
    output logic       o_illegal
);

    // Function-field legality is independent of alu_op so DECODE can screen early
    always_comb begin
        o_illegal = 1'b0;
        case (i_funct3)
            3'b010, 3'b011: o_illegal = 1'b1;
            3'b101:         o_illegal = i_funct7b5;
            default:        o_illegal = 1'b0;
        endcase
    end

    // Operation select; SUB only for R-type (op[5]=1) with instr[30] set
    always_comb begin
        o_alu_control = ALU_ADD;
        case (i_alu_op)
            ALUOP_SUB: o_alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (i_funct3)
                    3'b000:  o_alu_control = (i_op5 && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  o_alu_control = ALU_SHL;
                    3'b100:  o_alu_control = ALU_XOR;
                    3'b101:  o_alu_control = ALU_SHR;
                    3'b110:  o_alu_control = ALU_OR;
                    3'b111:  o_alu_control = ALU_AND;
                    default: o_alu_control = ALU_ADD;
                endcase
            end
            default: o_alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multicycle control FSM for the shared-datapath RV32I core. Moore outputs are
// registered with the state; only the FETCH handshake and branch resolution are
// qualified combinationally, and reset masks every output immediately.
module main_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit ENABLE_LUI      = 1'b1,
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       sign,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] imm_src,
    output logic [2:0] alu_control,
    output logic       illegal_instr
);

    state_t     r_state;
    state_t     w_next;
    ctrl_t      r_ctrl;
    logic [2:0] w_alu_control;
    logic       w_funct_illegal;
    logic       w_run;
    logic       w_taken;

    alu_decoder u_alu_decoder (
        .i_alu_op      (r_ctrl.alu_op),
        .i_funct3      (funct3),
        .i_funct7b5    (funct7b5),
        .i_op5         (op[5]),
        .o_alu_control (w_alu_control),
        .o_illegal     (w_funct_illegal)
    );

    function automatic ctrl_t moore_out(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.ir_write = 1'b1; c.pc_update = 1'b1;
                              c.alu_src_b = SRCB_FOUR; c.result_src = RES_ALU; end
            S_DECODE:   begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_IMM; end
            S_MEMADR:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM; end
            S_MEMREAD:  begin c.mem_req = 1'b1; c.adr_src = 1'b1; end
            S_MEMWB:    begin c.result_src = RES_RDATA; c.reg_write = 1'b1; end
            S_MEMWRITE: begin c.mem_req = 1'b1; c.mem_write = 1'b1; c.adr_src = 1'b1; end
            S_EXEC_R:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2;
                              c.alu_op = ALUOP_FUNCT; end
            S_EXEC_I:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_IMM;
                              c.alu_op = ALUOP_FUNCT; end
            S_EXEC_U:   begin c.alu_src_a = SRCA_ZERO; c.alu_src_b = SRCB_IMM; end
            S_ALUWB:    begin c.result_src = RES_ALUOUT; c.reg_write = 1'b1; end
            S_BRANCH:   begin c.alu_src_a = SRCA_RS1; c.alu_src_b = SRCB_RS2;
                              c.alu_op = ALUOP_SUB; c.branch = 1'b1; end
            S_JAL:      begin c.alu_src_a = SRCA_OLDPC; c.alu_src_b = SRCB_FOUR;
                              c.pc_update = 1'b1; end
            S_ILLEGAL:  begin c.illegal = TRAP_ON_ILLEGAL; end
            default:    c = '0;
        endcase
        return c;
    endfunction

    // Next-state selection, including opcode/funct screening in DECODE
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:    if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = w_funct_illegal ? S_ILLEGAL : S_EXEC_R;
                    OP_I:         w_next = w_funct_illegal ? S_ILLEGAL : S_EXEC_I;
                    OP_B:         w_next = branch_legal(funct3) ? S_BRANCH : S_ILLEGAL;
                    OP_JAL:       w_next = S_JAL;
                    OP_LUI:       w_next = ENABLE_LUI ? S_EXEC_U : S_ILLEGAL;
                    default:      w_next = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   w_next = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_EXEC_U, S_JAL: w_next = S_ALUWB;
            default:    w_next = S_FETCH;
        endcase
    end

    // State and its registered Moore control word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_ctrl  <= moore_out(S_FETCH);
        end else begin
            r_state <= w_next;
            r_ctrl  <= moore_out(w_next);
        end
    end

    assign w_run   = ~rst;
    assign w_taken = branch_taken(funct3, zero, sign);

    // FETCH is the only state with both pc_update and mem_req, so the
    // mem_ready qualification applies there and JAL's PC load stays unconditional.
    assign pc_write      = w_run & ((r_ctrl.pc_update & (mem_ready | ~r_ctrl.mem_req)) |
                                    (r_ctrl.branch & w_taken));
    assign ir_write      = w_run & r_ctrl.ir_write & mem_ready;
    assign mem_req       = w_run & r_ctrl.mem_req;
    assign mem_write     = w_run & r_ctrl.mem_write;
    assign adr_src       = w_run & r_ctrl.adr_src;
    assign reg_write     = w_run & r_ctrl.reg_write;
    assign illegal_instr = w_run & r_ctrl.illegal;
    assign alu_src_a     = w_run ? r_ctrl.alu_src_a  : 2'b00;
    assign alu_src_b     = w_run ? r_ctrl.alu_src_b  : 2'b00;
    assign result_src    = w_run ? r_ctrl.result_src : 2'b00;
    assign imm_src       = w_run ? imm_sel(op)       : 3'b000;
    assign alu_control   = w_run ? w_alu_control     : 3'b000;

endmodule
